// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, ISA fields and datapath mux selects.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RST,
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_WB_ALU,
      S_MEM_ADDR,
      S_MEM_RD,
      S_WB_MEM,
      S_MEM_WR,
      S_BRANCH,
      S_JUMP,
      S_HALT
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [2:0] EXT_ZERO = 3'b000;
   localparam logic [2:0] EXT_SIGN = 3'b001;
   localparam logic [2:0] EXT_LUI  = 3'b010;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_OR   = 3'b010;

   localparam logic [1:0] PC_SEL_PC4 = 2'b00;
   localparam logic [1:0] PC_SEL_BR  = 2'b01;
   localparam logic [1:0] PC_SEL_JMP = 2'b10;
   localparam logic [1:0] PC_SEL_REG = 2'b11;

   localparam logic [1:0] WD_SEL_ALU = 2'b00;
   localparam logic [1:0] WD_SEL_MEM = 2'b01;
   localparam logic [1:0] WD_SEL_PC  = 2'b10;

   localparam logic [1:0] REG_DST_RT = 2'b00;
   localparam logic [1:0] REG_DST_RD = 2'b01;
   localparam logic [1:0] REG_DST_RA = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_EXT    = 2'b10;
   localparam logic [1:0] SRCB_EXT_SH = 2'b11;

   function automatic state_e decode_next(input logic [5:0] op, input logic [5:0] funct);
      state_e nxt;
      nxt = S_HALT;
      case (op)
         OP_RTYPE: begin
            if (funct == FN_ADDU || funct == FN_SUBU) nxt = S_EXEC_R;
            else if (funct == FN_JR)                  nxt = S_JUMP;
         end
         OP_ORI, OP_LUI: nxt = S_EXEC_I;
         OP_LW, OP_SW:   nxt = S_MEM_ADDR;
         OP_BEQ:         nxt = S_BRANCH;
         OP_J, OP_JAL:   nxt = S_JUMP;
         default:        nxt = S_HALT;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mc_ctrl_wait.sv
// Memory handshake wait counter: counts consecutive stalled cycles and flags the
// MEM_WAIT_MAX-th one so the controller can abandon the access in that same cycle.
module mc_ctrl_wait #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic stall_i,
   output logic expired_o
);

   localparam int CW = $clog2(MEM_WAIT_MAX + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Wait states only self-loop while stalled, so dropping stall_i doubles as the clear on state entry.
   always_comb begin
      cnt_d = '0;
      if (stall_i) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign expired_o = stall_i && (cnt_q == CW'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM sequencing PC/IR/GRF/ALU/DM per instruction.
// Optional perf counters (cyc_cnt, instr_cnt) exist only when MC_CTRL_PERF_EN is defined.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_wr,
   output logic [1:0] pc_sel,
   output logic       ir_wr,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       i_or_d,
   output logic       reg_wr,
   output logic [1:0] reg_dst,
   output logic [1:0] wd_sel,
   output logic [2:0] ext_op,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic       illegal,
   output logic       mem_timeout
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [31:0] cyc_cnt,
   output logic [31:0] instr_cnt
`endif
);

   state_e     state_q, state_d;
   logic [5:0] op_q, funct_q;
   logic       timeout_q, timeout_d;
   logic       stall, wait_expired;

   assign stall = (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR) && !mem_ready;

   mc_ctrl_wait #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait (
      .clk_i    (clk),
      .rst_ni   (reset),
      .stall_i  (stall),
      .expired_o(wait_expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_RST;
         op_q      <= '0;
         funct_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timeout_q <= timeout_d;
         if (state_q == S_DECODE) begin
            op_q    <= op;
            funct_q <= funct;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      timeout_d = timeout_q;
      pc_wr     = 1'b0;
      pc_sel    = PC_SEL_PC4;
      ir_wr     = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      i_or_d    = 1'b0;
      reg_wr    = 1'b0;
      reg_dst   = REG_DST_RT;
      wd_sel    = WD_SEL_ALU;
      ext_op    = EXT_ZERO;
      alu_src_b = SRCB_B;
      alu_op    = ALU_ADD;
      illegal   = 1'b0;
      case (state_q)
         S_RST: state_d = S_FETCH;
         S_FETCH: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               ir_wr     = 1'b1;
               pc_wr     = 1'b1;
               alu_src_b = SRCB_FOUR;
               state_d   = S_DECODE;
            end else if (wait_expired) begin
               timeout_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_DECODE: begin
            ext_op    = EXT_SIGN;
            alu_src_b = SRCB_EXT_SH;
            state_d   = decode_next(op, funct);
         end
         S_EXEC_R: begin
            alu_op  = (funct_q == FN_SUBU) ? ALU_SUB : ALU_ADD;
            state_d = S_WB_ALU;
         end
         S_EXEC_I: begin
            // lui relies on A holding $0, so OR passes the shifted immediate through.
            ext_op    = (op_q == OP_LUI) ? EXT_LUI : EXT_ZERO;
            alu_src_b = SRCB_EXT;
            alu_op    = ALU_OR;
            state_d   = S_WB_ALU;
         end
         S_WB_ALU: begin
            reg_wr  = 1'b1;
            reg_dst = (op_q == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
            state_d = S_FETCH;
         end
         S_MEM_ADDR: begin
            ext_op    = EXT_SIGN;
            alu_src_b = SRCB_EXT;
            state_d   = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD, S_MEM_WR: begin
            mem_rd = (state_q == S_MEM_RD);
            mem_wr = (state_q == S_MEM_WR);
            i_or_d = 1'b1;
            if (mem_ready) begin
               state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
            end else if (wait_expired) begin
               timeout_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_WB_MEM: begin
            reg_wr  = 1'b1;
            wd_sel  = WD_SEL_MEM;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            alu_op  = ALU_SUB;
            pc_wr   = zero;
            pc_sel  = PC_SEL_BR;
            state_d = S_FETCH;
         end
         S_JUMP: begin
            pc_wr  = 1'b1;
            pc_sel = (op_q == OP_RTYPE) ? PC_SEL_REG : PC_SEL_JMP;
            if (op_q == OP_JAL) begin
               reg_wr  = 1'b1;
               reg_dst = REG_DST_RA;
               wd_sel  = WD_SEL_PC;
            end
            state_d = S_FETCH;
         end
         S_HALT:  illegal = 1'b1;
         default: state_d = S_RST;
      endcase
   end

   assign mem_timeout = timeout_q;

`ifdef MC_CTRL_PERF_EN
   logic [31:0] cyc_q, instr_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_q   <= '0;
         instr_q <= '0;
      end else begin
         if (state_q != S_RST && state_q != S_HALT) cyc_q <= cyc_q + 32'd1;
         if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_RST) instr_q <= instr_q + 32'd1;
      end
   end

   assign cyc_cnt   = cyc_q;
   assign instr_cnt = instr_q;
`endif

endmodule
